lsu_master: RTL and testbench
=============================

Name: lsu_master

Overview:
- Load/store initiator in the MEM stage. Takes one load/store request from the pipeline and converts it into a word-aligned, byte-enabled request on a req/ack memory port.
- Returns sign- or zero-extended load data and flags misaligned or timed-out accesses.
- It is the requesting side of the data-memory interface: the CPU stalls on `ready` low and resumes on the `done` pulse.

Parameters:
- `TIMEOUT`, 255: maximum number of cycles in ISSUE waiting for `mem_ack` before a bus error is raised.
- `AW`, 32: address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request strobe; sampled only when `ready`=1.
- `op` in 3: access kind (package encoding).
- `addr` in AW: byte address from the ALU.
- `wdata` in 32: store data, right-justified.
- `pc` in 32: PC of the instruction; used only for trace.
- `ready` out 1: unit idle and can accept `start`.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: extended load result; held until the next `done`.
- `addr_err` out 1: misaligned access; valid with `done`.
- `bus_err` out 1: timeout; valid with `done`.
- `mem_req` out 1: memory request, held until ack.
- `mem_we` out 1: 1 = write.
- `mem_be` out 4: byte enables.
- `mem_addr` out AW: word address, bits [1:0] = 0.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: memory accepted or completed the request.
- `mem_rdata` in 32: read word; valid when `mem_ack`=1 and `mem_we`=0.

Behaviour:
- States: IDLE, ISSUE, RESP.
- All outputs are registered. Reset value of every output is 0, except `ready`, which resets to 1.
- IDLE (`ready`=1):
  - On `start`, latch `op`, `addr`, `wdata`, `pc`.
  - If misaligned, go to RESP with `addr_err`=1 and no memory request. Misaligned means: LW/SW with `addr[1:0]`≠0, or LH/LHU/SH with `addr[0]`≠0.
  - Otherwise go to ISSUE. `mem_req`=1 from the next cycle, so the earliest request is cycle 1 after `start`.
- ISSUE: `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata` are all held stable.
  - On `mem_ack`, capture `mem_rdata`, drop `mem_req` and go to RESP. An ack in the first ISSUE cycle is legal, giving minimum latency `start`→`done` of 2 cycles.
  - A cycle counter runs from 0. If it reaches `TIMEOUT` without an ack, drop `mem_req`, set `bus_err`=1 and go to RESP.
  - `mem_ack` arriving in the same cycle the counter reaches `TIMEOUT`: the ack wins.
- RESP: `done`=1 for exactly one cycle, with the error flags valid. Then go to IDLE. `ready`=0 in ISSUE and RESP.
- `start` while `ready`=0 is ignored. There are no back-to-back accepts from RESP.
- `mem_ack` seen in IDLE or RESP is ignored.
- Byte enables:
  - Loads drive `mem_be`=4'b1111.
  - SW: `mem_be`=1111.
  - SH: `mem_be`=0011 when `addr[1]`=0, else 1100; `mem_wdata`={2{wdata[15:0]}}.
  - SB: `mem_be`=1<<`addr[1:0]`; `mem_wdata`={4{wdata[7:0]}}.
- Load extraction: select the lane by `addr[1:0]`. LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- On an error, `rdata` is unchanged.
- `reset` asserted mid-transaction: return to IDLE at that edge and drop `mem_req` immediately. The captured request is discarded and no `done` is produced.

Optional Feature:
- Macro: `LSU_TRACE_EN`.
- Defined: on the cycle a store's `mem_ack` is accepted, print `$display("%d@%h: *%h <= %h", $time, pc, mem_addr, merged_word)`. `merged_word` is `mem_wdata` with disabled lanes shown as 0.
- Undefined: no display statements. Logic is identical either way.

Decomposition:
- Package `lsu_pkg` holds:
  - op encoding LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7;
  - state enum;
  - helpers `is_store(op)` and `is_misaligned(op,a)`.
- One natural sub-module, `lsu_load_ext`: combinational lane select and extension (`op`, `addr[1:0]`, word → 32-bit result). The FSM and the store-lane logic stay in the top module.

Test Plan:
- SW `addr`=0x10, `wdata`=0xDEADBEEF, ack after 3 cycles → `mem_addr`=0x10, `be`=1111, `mem_we`=1, `done` one cycle, no errors.
- SB `addr`=0x13, `wdata`=0x000000A5 → `be`=1000, `mem_wdata`=0xA5A5A5A5; SH `addr`=0x12 → `be`=1100.
- LB `addr`=0x21, `mem_rdata`=0x1234F600 → `rdata`=0xFFFFFFF6; LBU same → 0x000000F6; LH `addr`=0x22 with `mem_rdata`=0x80011234 → 0xFFFF8001.
- LW `addr`=0x06 → `addr_err`=1, `done` at cycle 1, `mem_req` never asserted; LH `addr`=0x05 → `addr_err`.
- No ack, `TIMEOUT`=4 → `mem_req` high 4 cycles, then `done`+`bus_err`; ack on the 4th cycle instead → normal completion.
- `reset` pulsed in ISSUE → `mem_req`=0 at that edge, `ready`=1, no `done`; a late `mem_ack` is ignored; a new LW then completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store initiator: op encoding, FSM states, decode helpers.
// Optional trace output in lsu_master is enabled with LSU_TRACE_EN.
package lsu_pkg;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LH  = 3'd1,
    LHU = 3'd2,
    LB  = 3'd3,
    LBU = 3'd4,
    SW  = 3'd5,
    SH  = 3'd6,
    SB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  function automatic logic is_store(input op_e op);
    return (op == SW) || (op == SH) || (op == SB);
  endfunction

  function automatic logic is_misaligned(input op_e op, input logic [1:0] a);
    case (op)
      LW, SW:      return a != 2'b00;
      LH, LHU, SH: return a[0];
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load lane select and sign/zero extension of the returned memory word.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  op_e         op_i,
  input  logic [1:0]  alo_i,
  input  logic [31:0] word_i,
  output logic [31:0] res_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word_i[8*alo_i +: 8];
  assign half_sel = alo_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    res_o = word_i;
    case (op_i)
      LB:      res_o = {{24{byte_sel[7]}}, byte_sel};
      LBU:     res_o = {24'h0, byte_sel};
      LH:      res_o = {{16{half_sel[15]}}, half_sel};
      LHU:     res_o = {16'h0, half_sel};
      default: res_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu_master.sv
// MEM-stage load/store initiator driving a word-aligned req/ack port; all outputs registered.
// Define LSU_TRACE_EN to print accepted stores.
module lsu_master
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int AW      = 32
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic [2:0]    op_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  input  logic [31:0]   pc_i,
  output logic          ready_o,
  output logic          done_o,
  output logic [31:0]   rdata_o,
  output logic          addr_err_o,
  output logic          bus_err_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [3:0]    mem_be_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic [31:0]   mem_rdata_i
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  op_e           op_q, op_d;
  logic [1:0]    alo_q, alo_d;
  logic [31:0]   pc_q, pc_d;
  logic          ready_q, ready_d, done_q, done_d;
  logic          addr_err_q, addr_err_d, bus_err_q, bus_err_d;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
  logic [31:0]   ld_res;
  op_e           op_in;

  assign op_in = op_e'(op_i);

  lsu_load_ext u_load_ext (
    .op_i   (op_q),
    .alo_i  (alo_q),
    .word_i (mem_rdata_i),
    .res_o  (ld_res)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    alo_d       = alo_q;
    pc_d        = pc_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    addr_err_d  = 1'b0;
    bus_err_d   = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (start_i) begin
          op_d    = op_in;
          alo_d   = addr_i[1:0];
          pc_d    = pc_i;
          ready_d = 1'b0;
          cnt_d   = '0;
          if (is_misaligned(op_in, addr_i[1:0])) begin
            state_d    = RESP;
            done_d     = 1'b1;
            addr_err_d = 1'b1;
          end else begin
            state_d    = ISSUE;
            mem_req_d  = 1'b1;
            mem_we_d   = is_store(op_in);
            mem_addr_d = {addr_i[AW-1:2], 2'b00};
            // Sub-word stores replicate data across lanes; byte enables pick the target.
            case (op_in)
              SB: begin
                mem_be_d    = 4'b0001 << addr_i[1:0];
                mem_wdata_d = {4{wdata_i[7:0]}};
              end
              SH: begin
                mem_be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
                mem_wdata_d = {2{wdata_i[15:0]}};
              end
              default: begin
                mem_be_d    = 4'b1111;
                mem_wdata_d = wdata_i;
              end
            endcase
          end
        end
      end
      ISSUE: begin
        if (mem_ack_i) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          if (!mem_we_q) rdata_d = ld_res;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= LW;
      alo_q       <= '0;
      pc_q        <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      addr_err_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      alo_q       <= alo_d;
      pc_q        <= pc_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      addr_err_q  <= addr_err_d;
      bus_err_q   <= bus_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef LSU_TRACE_EN
  logic [31:0] merged_word;
  always_comb begin
    merged_word = '0;
    for (int i = 0; i < 4; i++)
      merged_word[8*i +: 8] = mem_be_q[i] ? mem_wdata_q[8*i +: 8] : 8'h00;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && state_q == ISSUE && mem_ack_i && mem_we_q)
      $display("%d@%h: *%h <= %h", $time, pc_q, mem_addr_q, merged_word);
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc_q;
`endif

  assign ready_o     = ready_q;
  assign done_o      = done_q;
  assign rdata_o     = rdata_q;
  assign addr_err_o  = addr_err_q;
  assign bus_err_o   = bus_err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_lsu_master.sv
// Bench for lsu_master: directed scenarios plus randomized transactions against a size/offset model.
module tb_lsu_master;

  localparam int TO = 4;
  localparam logic [2:0] OP_LW = 3'd0, OP_LH = 3'd1, OP_LHU = 3'd2, OP_LB = 3'd3,
                         OP_LBU = 3'd4, OP_SW = 3'd5, OP_SH = 3'd6, OP_SB = 3'd7;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] addr_i = '0, wdata_i = '0, pc_i = '0;
  logic        ready_o, done_o, addr_err_o, bus_err_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_rdata = '0;

  always #5 clk_i = ~clk_i;

  lsu_master #(.TIMEOUT(TO), .AW(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .op_i(op_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .pc_i(pc_i),
    .ready_o(ready_o), .done_o(done_o), .rdata_o(rdata_o),
    .addr_err_o(addr_err_o), .bus_err_o(bus_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  function automatic int size_of(input logic [2:0] op);
    if (op == OP_LW || op == OP_SW) return 4;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] w);
    longint v, span;
    span = longint'(1) << (8 * size_of(op));
    v = (longint'(w) >> (8 * (a % 4))) % span;
    if ((op == OP_LB || op == OP_LH) && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_txn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] mw, input int delay, input bit hold_start,
                         input string nm);
    int sz, be_int;
    bit st, mis, timeout;
    logic [3:0] ebe;
    logic [31:0] ewd, ea;
    logic [37:0] got_bus, exp_bus;
    sz = size_of(op);
    st = (op >= OP_SW);
    mis = (a % sz) != 0;
    be_int = st ? (((1 << sz) - 1) << (a % 4)) : 15;
    ebe = be_int[3:0];
    ewd = (sz == 1) ? {24'h0, wd[7:0]} * 32'h01010101 :
          (sz == 2) ? {16'h0, wd[15:0]} * 32'h00010001 : wd;
    ea = a & ~32'h3;
    for (int w = 0; w < 10 && !ready_o; w++) tick();
    n_chk++;
    if (ready_o !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_before_start: got %b want 1", nm, ready_o);
    end
    start_i = 1'b1; op_i = op; addr_i = a; wdata_i = wd; pc_i = $urandom;
    tick();
    if (hold_start) begin
      op_i = 3'($urandom); addr_i = $urandom; wdata_i = $urandom;
    end else start_i = 1'b0;
    if (mis) begin
      n_chk++;
      if ({done_o, addr_err_o, bus_err_o, mem_req_o, ready_o} !== 5'b11000) begin
        n_fail++;
        $display("FAIL %s misaligned_resp: got done/aerr/berr/req/rdy=%b want 11000", nm,
                 {done_o, addr_err_o, bus_err_o, mem_req_o, ready_o});
      end
    end else begin
      timeout = 1'b1;
      exp_bus = {1'b1, st, ebe, ea};
      for (int k = 0; k < TO; k++) begin
        got_bus = {mem_req_o, mem_we_o, mem_be_o, mem_addr_o};
        n_chk++;
        if (got_bus !== exp_bus || done_o !== 1'b0 || ready_o !== 1'b0) begin
          n_fail++;
          $display("FAIL %s issue_cyc%0d: got req/we/be/addr=%h done=%b rdy=%b want %h done=0 rdy=0",
                   nm, k, got_bus, done_o, ready_o, exp_bus);
        end
        if (st) begin
          n_chk++;
          if (mem_wdata_o !== ewd) begin
            n_fail++; $display("FAIL %s mem_wdata: got %h want %h", nm, mem_wdata_o, ewd);
          end
        end
        mem_ack_i = (k == delay);
        mem_rdata_i = mem_ack_i ? mw : $urandom;
        tick();
        mem_ack_i = 1'b0;
        if (k == delay) begin
          timeout = 1'b0;
          break;
        end
      end
      if (!timeout && !st) exp_rdata = model_load(op, a, mw);
      n_chk++;
      if ({done_o, addr_err_o, bus_err_o, mem_req_o, ready_o} !== {3'b10, timeout, 2'b00}) begin
        n_fail++;
        $display("FAIL %s resp: got done/aerr/berr/req/rdy=%b want %b", nm,
                 {done_o, addr_err_o, bus_err_o, mem_req_o, ready_o}, {3'b10, timeout, 2'b00});
      end
    end
    n_chk++;
    if (rdata_o !== exp_rdata) begin
      n_fail++; $display("FAIL %s rdata: got %h want %h", nm, rdata_o, exp_rdata);
    end
    mem_ack_i = 1'($urandom);
    tick();
    mem_ack_i = 1'b0;
    start_i = 1'b0;
    n_chk++;
    if ({done_o, ready_o, mem_req_o} !== 3'b010) begin
      n_fail++;
      $display("FAIL %s after_resp: got done/rdy/req=%b want 010", nm, {done_o, ready_o, mem_req_o});
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) tick();
    reset_i = 1'b0;
    n_chk++;
    if ({ready_o, done_o, rdata_o, addr_err_o, bus_err_o, mem_req_o, mem_we_o, mem_be_o,
         mem_addr_o, mem_wdata_o} !== {1'b1, 105'h0}) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%b done=%b rdata=%h aerr=%b berr=%b req=%b we=%b be=%h addr=%h wd=%h want rdy=1 rest 0",
               ready_o, done_o, rdata_o, addr_err_o, bus_err_o, mem_req_o, mem_we_o, mem_be_o,
               mem_addr_o, mem_wdata_o);
    end
    tick();
    exp_rdata = '0;
  endtask

  task automatic test_store();
    run_txn(OP_SW, 32'h10, 32'hDEADBEEF, 32'h0, 2, 1'b0, "sw_basic");
  endtask

  task automatic test_sub_word_store();
    run_txn(OP_SB, 32'h13, 32'h000000A5, 32'h0, 0, 1'b0, "sb_lane3");
    run_txn(OP_SH, 32'h12, 32'h0000C3D2, 32'h0, 1, 1'b0, "sh_upper");
  endtask

  task automatic test_load_ext();
    run_txn(OP_LB, 32'h21, 32'h0, 32'h1234F600, 0, 1'b0, "lb_sign");
    n_chk++;
    if (rdata_o !== 32'hFFFFFFF6) begin
      n_fail++; $display("FAIL lb_const: got %h want FFFFFFF6", rdata_o);
    end
    run_txn(OP_LBU, 32'h21, 32'h0, 32'h1234F600, 1, 1'b0, "lbu_zero");
    n_chk++;
    if (rdata_o !== 32'h000000F6) begin
      n_fail++; $display("FAIL lbu_const: got %h want 000000F6", rdata_o);
    end
    run_txn(OP_LH, 32'h22, 32'h0, 32'h80011234, 2, 1'b0, "lh_sign");
    n_chk++;
    if (rdata_o !== 32'hFFFF8001) begin
      n_fail++; $display("FAIL lh_const: got %h want FFFF8001", rdata_o);
    end
  endtask

  task automatic test_misaligned();
    run_txn(OP_LW, 32'h06, 32'h0, 32'h0, 0, 1'b0, "lw_misaligned");
    run_txn(OP_LH, 32'h05, 32'h0, 32'h0, 0, 1'b1, "lh_misaligned");
  endtask

  task automatic test_timeout();
    run_txn(OP_LW, 32'h30, 32'h0, 32'hCAFEF00D, -1, 1'b0, "timeout_noack");
    run_txn(OP_LW, 32'h34, 32'h0, 32'hCAFEF00D, TO - 1, 1'b0, "ack_on_last_cycle");
  endtask

  task automatic test_reset_mid();
    start_i = 1'b1; op_i = OP_LW; addr_i = 32'h40; wdata_i = '0;
    tick();
    start_i = 1'b0;
    n_chk++;
    if (mem_req_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_req_up: got %b want 1", mem_req_o);
    end
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    exp_rdata = '0;
    n_chk++;
    if ({mem_req_o, ready_o, done_o} !== 3'b010) begin
      n_fail++; $display("FAIL rst_mid_drop: got req/rdy/done=%b want 010", {mem_req_o, ready_o, done_o});
    end
    mem_ack_i = 1'b1; mem_rdata_i = 32'h55AA55AA;
    tick();
    mem_ack_i = 1'b0;
    n_chk++;
    if ({mem_req_o, ready_o, done_o, rdata_o} !== {3'b010, 32'h0}) begin
      n_fail++;
      $display("FAIL rst_late_ack: got req/rdy/done=%b rdata=%h want 010 rdata=0",
               {mem_req_o, ready_o, done_o}, rdata_o);
    end
    run_txn(OP_LW, 32'h44, 32'h0, 32'h0BADF00D, 1, 1'b0, "lw_after_reset");
  endtask

  task automatic test_random();
    logic [2:0] op;
    int d;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      d = $urandom_range(0, 8);
      run_txn(op, $urandom & 32'hFFFF, $urandom, $urandom, (d == 8) ? -1 : (d % TO),
              1'($urandom), "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store();
    test_sub_word_store();
    test_load_ext();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
